branch_resolve_unit: RTL and testbench

Parametrised branch resolution stage for the pipelined CPU, the successor to the combinational branch-condition test. It evaluates the six branch conditions on DATA_W-bit operands and registers the outcome. It compares the outcome against the fetch-time prediction and drives a one-cycle flush/redirect on mispredict. It also holds a BHT of saturating counters that supplies predictions to IF and is trained on every resolved branch, plus saturating branch/mispredict performance counters.

---
 rtl/branch_resolve_unit.sv | 75 +++++++
 tb/tb_branch_resolve_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves branch conditions, flushes on mispredict, trains a
// saturating-counter BHT and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 32,
   parameter int BHT_IDX_W = 4,
   parameter int CNT_W     = 2,
   parameter int PERF_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   if_pc,
   output logic              if_pred_taken,
   input  logic              ex_valid,
   input  logic              ex_kill,
   input  logic              stall,
   input  logic [4:0]        ex_alucode,
   input  logic [DATA_W-1:0] ex_rs,
   input  logic [DATA_W-1:0] ex_rt,
   input  logic [PC_W-1:0]   ex_pc,
   input  logic [PC_W-1:0]   ex_target,
   input  logic              ex_pred_taken,
   output logic              res_valid,
   output logic              res_taken,
   output logic              flush,
   output logic [PC_W-1:0]   redirect_pc,
   output logic [PERF_W-1:0] br_count,
   output logic [PERF_W-1:0] mispred_count
);
   localparam logic [CNT_W-1:0] BHT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
   logic                 isBranch, rsNeg, rsZero, cond, accept, mispredict;
   logic [BHT_IDX_W-1:0] ifIdx, exIdx;
   logic [CNT_W-1:0]     bht [2**BHT_IDX_W];
   logic [CNT_W-1:0]     cnt, cntNext;
   logic                 unusedPcBits;
   assign unusedPcBits = ^{if_pc[PC_W-1:BHT_IDX_W+2], if_pc[1:0]};
   always_comb begin
      isBranch      = ex_alucode[4:3] == 2'b01 && ex_alucode[2:1] != 2'b00;
      rsNeg         = ex_rs[DATA_W-1];
      rsZero        = ex_rs == '0;
      cond          = ex_alucode[2:0] == 3'b010 ? ex_rs == ex_rt :
                      ex_alucode[2:0] == 3'b011 ? ex_rs != ex_rt :
                      ex_alucode[2:0] == 3'b100 ? !rsNeg :
                      ex_alucode[2:0] == 3'b101 ? !rsNeg && !rsZero :
                      ex_alucode[2:0] == 3'b110 ? rsNeg || rsZero : rsNeg;
      accept        = ex_valid && !ex_kill && !stall && isBranch;
      mispredict    = cond != ex_pred_taken;
      ifIdx         = if_pc[BHT_IDX_W+1:2];
      exIdx         = ex_pc[BHT_IDX_W+1:2];
      if_pred_taken = bht[ifIdx][CNT_W-1];
      cnt           = bht[exIdx];
      cntNext       = cond ? (cnt == '1 ? cnt : cnt + CNT_W'(1)) : (cnt == '0 ? cnt : cnt - CNT_W'(1));
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid     <= 1'b0;
         res_taken     <= 1'b0;
         flush         <= 1'b0;
         redirect_pc   <= '0;
         br_count      <= '0;
         mispred_count <= '0;
         for (int i = 0; i < 2**BHT_IDX_W; i++) bht[i] <= BHT_INIT;
      end else begin
         res_valid <= accept;
         flush     <= accept && mispredict;
         if (accept) begin
            res_taken   <= cond;
            redirect_pc <= cond ? ex_target : ex_pc + PC_W'(4);
            bht[exIdx]  <= cntNext;
            if (br_count != '1) br_count <= br_count + PERF_W'(1);
            if (mispredict && mispred_count != '1) mispred_count <= mispred_count + PERF_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural model of the resolution stage.
module tb_branch_resolve_unit;
   localparam int PW = 4;
   logic          clk = 0, rst_n = 0;
   logic [31:0]   if_pc = 0, ex_rs = 0, ex_rt = 0, ex_pc = 0, ex_target = 0;
   logic          ex_valid = 0, ex_kill = 0, stall = 0, ex_pred_taken = 0;
   logic [4:0]    ex_alucode = 0;
   logic          if_pred_taken, res_valid, res_taken, flush;
   logic [31:0]   redirect_pc;
   logic [PW-1:0] br_count, mispred_count;
   int checks = 0, errors = 0;
   int bhtM[16];
   int brM = 0, misM = 0, idx;
   bit mValid = 0, mTaken = 0, mFlush = 0, started = 0, acc, c;
   logic [31:0] mRedir = 0;
   logic [31:0] rsList[4] = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
   bit upExp[4]   = '{1, 1, 1, 1};
   bit downExp[4] = '{1, 0, 0, 0};

   branch_resolve_unit #(.PERF_W(PW)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .ex_valid(ex_valid), .ex_kill(ex_kill), .stall(stall), .ex_alucode(ex_alucode),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .res_valid(res_valid), .res_taken(res_taken),
      .flush(flush), .redirect_pc(redirect_pc), .br_count(br_count), .mispred_count(mispred_count));

   always #5 clk = ~clk;

   function automatic bit isBr(logic [4:0] code);
      return code inside {5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
   endfunction

   function automatic bit condM(logic [4:0] code, logic [31:0] rs, logic [31:0] rt);
      case (code)
         5'd10:   return rs == rt;
         5'd11:   return rs != rt;
         5'd12:   return $signed(rs) >= 0;
         5'd13:   return $signed(rs) > 0;
         5'd14:   return $signed(rs) <= 0;
         5'd15:   return $signed(rs) < 0;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model updates on the same edge the DUT samples its inputs.
   always @(posedge clk) begin
      started = 1;
      if (!rst_n) begin
         foreach (bhtM[i]) bhtM[i] = 1;
         brM = 0; misM = 0; mValid = 0; mTaken = 0; mFlush = 0; mRedir = 0;
      end else begin
         acc    = ex_valid && !ex_kill && !stall && isBr(ex_alucode);
         mValid = acc;
         mFlush = 0;
         if (acc) begin
            c      = condM(ex_alucode, ex_rs, ex_rt);
            mTaken = c;
            mFlush = c != ex_pred_taken;
            mRedir = c ? ex_target : ex_pc + 32'd4;
            idx    = int'((ex_pc >> 2) & 32'd15);
            bhtM[idx] = c ? (bhtM[idx] < 3 ? bhtM[idx] + 1 : 3) : (bhtM[idx] > 0 ? bhtM[idx] - 1 : 0);
            brM    = brM < 15 ? brM + 1 : 15;
            if (mFlush) misM = misM < 15 ? misM + 1 : 15;
         end
      end
   end

   always @(negedge clk) if (started) begin
      chk("res_valid", res_valid, mValid);
      chk("res_taken", res_taken, mTaken);
      chk("flush", flush, mFlush);
      chk("redirect_pc", redirect_pc, mRedir);
      chk("br_count", br_count, brM);
      chk("mispred_count", mispred_count, misM);
      chk("if_pred_taken", if_pred_taken, bhtM[(if_pc >> 2) & 32'd15] >= 2);
   end

   task automatic br(input logic [4:0] code, input logic [31:0] rs, rt, pc, tgt,
                     input bit pred, input bit stl = 0, input bit kil = 0);
      ex_valid = 1; ex_alucode = code; ex_rs = rs; ex_rt = rt; ex_pc = pc;
      ex_target = tgt; ex_pred_taken = pred; stall = stl; ex_kill = kil;
      @(negedge clk); #1;
      ex_valid = 0; stall = 0; ex_kill = 0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst res_valid", res_valid, 0);
      chk("rst br_count", br_count, 0);
      chk("rst pred", if_pred_taken, 0);
      rst_n = 1; if_pc = 32'h100;
      @(negedge clk); #1;
      // First beq: read-before-write keeps the old counter visible this cycle.
      chk("pred before train", if_pred_taken, 0);
      br(5'd10, 32'h5, 32'h5, 32'h100, 32'h200, 0);
      chk("t1 res_taken", res_taken, 1);
      chk("t1 flush", flush, 1);
      chk("t1 redirect", redirect_pc, 32'h200);
      chk("t1 br_count", br_count, 1);
      chk("t1 mispred", mispred_count, 1);
      chk("t1 pred after train", if_pred_taken, 1);
      @(negedge clk); #1;
      chk("t1 pulse ends", res_valid, 0);
      br(5'd11, 32'h1, 32'h2, 32'h80, 32'h300, 0, 1, 0);
      chk("stall res_valid", res_valid, 0);
      br(5'd11, 32'h1, 32'h2, 32'h80, 32'h300, 0, 0, 1);
      chk("kill res_valid", res_valid, 0);
      chk("stall/kill br_count", br_count, 1);
      for (int r = 0; r < 4; r++)
         for (int k = 10; k < 16; k++) begin
            br(5'(k), rsList[r], 32'h1, 32'h1000 + 32'(4 * k), 32'h2000, 0);
            if (rsList[r] == 0 && k == 13) chk("bgtz zero", res_taken, 0);
            if (rsList[r] == 0 && k == 14) chk("blez zero", res_taken, 1);
         end
      br(5'd0, 32'h1, 32'h1, 32'h1000, 32'h2000, 0);
      chk("nonbranch res_valid", res_valid, 0);
      br(5'd11, 32'h7, 32'h7, 32'hFFFF_FFFC, 32'h500, 1);
      chk("wrap redirect", redirect_pc, 32'h0);
      chk("wrap flush", flush, 1);
      for (int i = 0; i < 20; i++) br(5'd12, 32'h0, 32'h0, 32'h800, 32'h900, 1);
      chk("perf sat", br_count, 15);
      if_pc = 32'h40;
      br(5'd10, 32'h1, 32'h1, 32'h40, 32'h44, 0);
      chk("pre-reset pred", if_pred_taken, 1);
      rst_n = 0;
      @(negedge clk); #1;
      chk("midrst res_valid", res_valid, 0);
      chk("midrst flush", flush, 0);
      chk("midrst br_count", br_count, 0);
      chk("midrst mispred", mispred_count, 0);
      chk("midrst pred", if_pred_taken, 0);
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         br(5'd10, 32'h3, 32'h3, 32'h40, 32'h80, 0);
         chk("sat up pred", if_pred_taken, upExp[i]);
      end
      for (int i = 0; i < 4; i++) begin
         br(5'd11, 32'h3, 32'h3, 32'h40, 32'h80, 1);
         chk("sat down pred", if_pred_taken, downExp[i]);
      end
      @(negedge clk); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
